matrix_stack: RTL and testbench
===============================

Name: matrix_stack

Overview:
- Dual transform-matrix stack (modelview, projection) that terminates the matrix write port driven by the matrix multiplier.
- Holds the current top-of-stack 4x4 matrix per mode and presents it on the matrix_peek_* buses.
- Implements GL-style push, pop, load-identity and whole-matrix write.
- Tracks stack depth and latches sticky overflow/underflow errors for the command decoder.

Parameters:
- DEPTH, 8, saved levels per mode, excluding the top register.
- PTR_W, 4, depth counter width; must satisfy 2^PTR_W > DEPTH.
- ONE, 32'h3F800000, encoding of 1.0 used for identity diagonals.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- matrix_mode_in  in  1  selects the target stack for every command and for peek; 0 = modelview, 1 = projection
- matrix_write_en  in  1  one-cycle strobe; replaces the selected top with matrix_write_in_0..3
- matrix_write_in_0..3  in  128 each  rows 0..3; element column 0 in [127:96], column 3 in [31:0]
- push  in  1  one-cycle strobe; saves a copy of the selected top
- pop  in  1  one-cycle strobe; restores the most recently saved matrix to the selected top
- load_identity  in  1  one-cycle strobe; sets the selected top to identity
- err_clr  in  1  clears both sticky error flags
- matrix_peek_0..3  out  128 each  rows of the selected top (combinational mux from the top registers)
- depth_mv  out  PTR_W  modelview saved-level count
- depth_proj  out  PTR_W  projection saved-level count
- overflow  out  1  sticky; a push was attempted on a full stack
- underflow  out  1  sticky; a pop was attempted on an empty stack

Behaviour:
- Reset (asynchronous, rst_n low):
  - both tops = identity; row r has ONE at column r, zeros elsewhere
  - depth_mv = depth_proj = 0; overflow = underflow = 0
  - saved-level storage contents are don't-care
- Command decode:
  - one command executes per rising edge, on the stack selected by matrix_mode_in in that cycle
  - the unselected stack is never modified
- Priority when several strobes are high in the same cycle: matrix_write_en > load_identity > push > pop. Lower-priority strobes in that cycle are ignored and raise no error.
- Write: top <= {matrix_write_in_0..3}; depth unchanged.
- Load identity: top <= identity; depth unchanged.
- Push:
  - depth < DEPTH: save[depth] <= top; depth <= depth+1; top unchanged (the duplicate stays current).
  - depth == DEPTH: no state change; overflow <= 1.
- Pop:
  - depth > 0: top <= save[depth-1]; depth <= depth-1.
  - depth == 0: no state change; top keeps its value; underflow <= 1.
- Latency: every command's effect is visible on matrix_peek_* and depth_* in the cycle after the edge that executes it.
- Peek path: matrix_mode_in changes reach matrix_peek_* combinationally, with no added latency. This lets the multiplier switch modes between its vector passes without stalling.
- err_clr:
  - clears both flags at the edge.
  - If an error event occurs in the same cycle, set wins and the flag ends at 1.
- Depth counters never wrap.
- Storage: per mode, DEPTH x 512 bits, kept as registers or distributed RAM. Each level is written with all four rows in a single cycle.
- Reset asserted mid-operation: all state returns to the reset values immediately; a command sampled in that cycle is lost.

Test Plan:
- Reset, then read with mode 0 and mode 1 -> matrix_peek_0 = {3F800000,0,0,0} and matrix_peek_3 = {0,0,0,3F800000} in both modes; depths 0; flags 0.
- Mode 0: write matrix A (row0 = 128'h1..., distinct per row), push, write B, pop -> peek returns A; depth_mv sequence 0,1,0; depth_proj stays 0; projection still identity.
- Mode 1: push DEPTH+1 times -> depth_proj = 8 after eight pushes; ninth push sets overflow, depth stays 8, top unchanged. Then err_clr -> overflow 0.
- Mode 0 from reset: pop -> underflow = 1, top stays identity, depth_mv = 0. err_clr and a second pop in the same cycle -> underflow remains 1.
- Same cycle, mode 0: matrix_write_en + push + pop with data C -> top = C; depth_mv unchanged; no flags.
- Mode 1: write D, push, load_identity, then toggle matrix_mode_in to 0 -> peek immediately shows modelview top; back to 1 shows identity; pop -> D.

Source files
------------

// File: rtl/matrix_stack.sv
// Dual 4x4 transform-matrix stack (modelview / projection) with GL-style push, pop,
// load-identity and whole-matrix write. The top of each stack lives in registers for a zero-latency peek.
`timescale 1ns/1ps
module matrix_stack #(
    parameter int          DEPTH = 8,
    parameter int          PTR_W = 4,
    parameter logic [31:0] ONE   = 32'h3F800000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               matrix_mode_in,
    input  logic               matrix_write_en,
    input  logic [127:0]       matrix_write_in_0,
    input  logic [127:0]       matrix_write_in_1,
    input  logic [127:0]       matrix_write_in_2,
    input  logic [127:0]       matrix_write_in_3,
    input  logic               push,
    input  logic               pop,
    input  logic               load_identity,
    input  logic               err_clr,
    output logic [127:0]       matrix_peek_0,
    output logic [127:0]       matrix_peek_1,
    output logic [127:0]       matrix_peek_2,
    output logic [127:0]       matrix_peek_3,
    output logic [PTR_W-1:0]   depth_mv,
    output logic [PTR_W-1:0]   depth_proj,
    output logic               overflow,
    output logic               underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Row 0 occupies [511:384]; within a row column 0 is the most significant word.
    localparam logic [511:0] IDENTITY = {ONE, 96'd0,
                                         32'd0, ONE, 64'd0,
                                         64'd0, ONE, 32'd0,
                                         96'd0, ONE};

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_WRITE,
        CMD_IDENT,
        CMD_PUSH,
        CMD_POP
    } cmd_e;

    logic [511:0]     r_top   [2];
    logic [511:0]     r_save  [2][DEPTH];
    logic [PTR_W-1:0] r_depth [2];
    logic             r_overflow;
    logic             r_underflow;

    cmd_e             w_cmd;
    logic [PTR_W-1:0] w_depth_sel;
    logic [511:0]     w_top_sel;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_pop_idx;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_cmd = CMD_NONE;
        if (matrix_write_en)    w_cmd = CMD_WRITE;
        else if (load_identity) w_cmd = CMD_IDENT;
        else if (push)          w_cmd = CMD_PUSH;
        else if (pop)           w_cmd = CMD_POP;
    end

    assign w_depth_sel = r_depth[matrix_mode_in];
    assign w_top_sel   = r_top[matrix_mode_in];
    assign w_push_ok   = (w_cmd == CMD_PUSH) && (w_depth_sel <  PTR_W'(DEPTH));
    assign w_ovf_evt   = (w_cmd == CMD_PUSH) && (w_depth_sel >= PTR_W'(DEPTH));
    assign w_pop_ok    = (w_cmd == CMD_POP)  && (w_depth_sel != '0);
    assign w_unf_evt   = (w_cmd == CMD_POP)  && (w_depth_sel == '0);
    assign w_push_idx  = AW'(w_depth_sel);
    assign w_pop_idx   = AW'(w_depth_sel - PTR_W'(1));

    // NOTE: saved levels carry no reset so they can map onto distributed RAM; depth gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_save[matrix_mode_in][w_push_idx] <= w_top_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top[0]    <= IDENTITY;
            r_top[1]    <= IDENTITY;
            r_depth[0]  <= '0;
            r_depth[1]  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            unique case (w_cmd)
                CMD_WRITE: r_top[matrix_mode_in] <= {matrix_write_in_0, matrix_write_in_1,
                                                     matrix_write_in_2, matrix_write_in_3};
                CMD_IDENT: r_top[matrix_mode_in] <= IDENTITY;
                CMD_POP:   if (w_pop_ok) r_top[matrix_mode_in] <= r_save[matrix_mode_in][w_pop_idx];
                default:   ;
            endcase

            if (w_push_ok)     r_depth[matrix_mode_in] <= w_depth_sel + PTR_W'(1);
            else if (w_pop_ok) r_depth[matrix_mode_in] <= w_depth_sel - PTR_W'(1);

            // A fresh error event outranks a clear arriving in the same cycle.
            r_overflow  <= w_ovf_evt | (r_overflow  & ~err_clr);
            r_underflow <= w_unf_evt | (r_underflow & ~err_clr);
        end
    end

    assign matrix_peek_0 = w_top_sel[511:384];
    assign matrix_peek_1 = w_top_sel[383:256];
    assign matrix_peek_2 = w_top_sel[255:128];
    assign matrix_peek_3 = w_top_sel[127:0];
    assign depth_mv      = r_depth[0];
    assign depth_proj    = r_depth[1];
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_matrix_stack.sv
// Self-checking bench for matrix_stack: a behavioural stack model feeds a scoreboard queue,
// and each DUT observation pops and compares the oldest expectation.
`timescale 1ns/1ps
module tb_matrix_stack;

    localparam int          DEPTH = 8;
    localparam int          PTR_W = 4;
    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [511:0] IDENT = {ONE, 96'd0, 32'd0, ONE, 64'd0, 64'd0, ONE, 32'd0, 96'd0, ONE};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               matrix_mode_in = 1'b0;
    logic               matrix_write_en = 1'b0;
    logic [127:0]       matrix_write_in_0 = '0;
    logic [127:0]       matrix_write_in_1 = '0;
    logic [127:0]       matrix_write_in_2 = '0;
    logic [127:0]       matrix_write_in_3 = '0;
    logic               push = 1'b0;
    logic               pop = 1'b0;
    logic               load_identity = 1'b0;
    logic               err_clr = 1'b0;
    logic [127:0]       matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3;
    logic [PTR_W-1:0]   depth_mv, depth_proj;
    logic               overflow, underflow;

    matrix_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ONE(ONE)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .matrix_mode_in    (matrix_mode_in),
        .matrix_write_en   (matrix_write_en),
        .matrix_write_in_0 (matrix_write_in_0),
        .matrix_write_in_1 (matrix_write_in_1),
        .matrix_write_in_2 (matrix_write_in_2),
        .matrix_write_in_3 (matrix_write_in_3),
        .push              (push),
        .pop               (pop),
        .load_identity     (load_identity),
        .err_clr           (err_clr),
        .matrix_peek_0     (matrix_peek_0),
        .matrix_peek_1     (matrix_peek_1),
        .matrix_peek_2     (matrix_peek_2),
        .matrix_peek_3     (matrix_peek_3),
        .depth_mv          (depth_mv),
        .depth_proj        (depth_proj),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [511:0]     top;
        logic [PTR_W-1:0] dmv;
        logic [PTR_W-1:0] dpj;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t         sb[$];
    logic [511:0] m_top  [2];
    logic [511:0] m_save [2][DEPTH];
    int           m_depth[2];
    logic         m_ovf, m_unf;
    int           n_vec = 0;
    int           n_mis = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [511:0] mk(input logic [7:0] b);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[511-32*i -: 32] = {b, 8'h00, 16'(i)};
        return v;
    endfunction

    task automatic model_reset();
        m_top[0]   = IDENT;
        m_top[1]   = IDENT;
        m_depth[0] = 0;
        m_depth[1] = 0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    task automatic model_cmd(input logic mode, input logic we, input logic [511:0] data,
                             input logic ld, input logic ps, input logic pp, input logic ec);
        logic eo, eu;
        int   m;
        eo = 1'b0;
        eu = 1'b0;
        m  = int'(mode);
        if (we) m_top[m] = data;
        else if (ld) m_top[m] = IDENT;
        else if (ps) begin
            if (m_depth[m] < DEPTH) begin
                m_save[m][m_depth[m]] = m_top[m];
                m_depth[m]++;
            end else eo = 1'b1;
        end else if (pp) begin
            if (m_depth[m] > 0) begin
                m_depth[m]--;
                m_top[m] = m_save[m][m_depth[m]];
            end else eu = 1'b1;
        end
        m_ovf = eo | (m_ovf & ~ec);
        m_unf = eu | (m_unf & ~ec);
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.top = m_top[int'(matrix_mode_in)];
        e.dmv = PTR_W'(m_depth[0]);
        e.dpj = PTR_W'(m_depth[1]);
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);
    endtask

    task automatic compare_one();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL scoreboard: got empty queue want an entry");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".top"}, {matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3}, e.top);
        check({e.tag, ".dmv"}, 512'(depth_mv),   512'(e.dmv));
        check({e.tag, ".dpj"}, 512'(depth_proj), 512'(e.dpj));
        check({e.tag, ".ovf"}, 512'(overflow),   512'(e.ovf));
        check({e.tag, ".unf"}, 512'(underflow),  512'(e.unf));
    endtask

    task automatic do_cmd(input string tag, input logic mode, input logic we, input logic [511:0] data,
                          input logic ld, input logic ps, input logic pp, input logic ec);
        @(negedge clk);
        matrix_mode_in  = mode;
        matrix_write_en = we;
        {matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3} = data;
        load_identity   = ld;
        push            = ps;
        pop             = pp;
        err_clr         = ec;
        model_cmd(mode, we, data, ld, ps, pp, ec);
        push_exp(tag);
        @(posedge clk);
        #1;
        matrix_write_en = 1'b0;
        load_identity   = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        err_clr         = 1'b0;
        compare_one();
    endtask

    // Mode change with no clock edge: the peek bus must follow immediately.
    task automatic peek_at(input string tag, input logic mode);
        matrix_mode_in = mode;
        #1;
        push_exp(tag);
        compare_one();
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        push_exp(tag);
        compare_one();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] a, b, c, d, rnd;
        a = mk(8'h11);
        b = mk(8'h22);
        c = mk(8'h33);
        d = mk(8'h44);

        model_reset();
        apply_reset("reset");
        peek_at("rst_mode0", 1'b0);
        check("rst_m0_row0", 512'(matrix_peek_0), 512'({ONE, 96'd0}));
        check("rst_m0_row3", 512'(matrix_peek_3), 512'({96'd0, ONE}));
        peek_at("rst_mode1", 1'b1);
        check("rst_m1_row0", 512'(matrix_peek_0), 512'({ONE, 96'd0}));
        check("rst_m1_row3", 512'(matrix_peek_3), 512'({96'd0, ONE}));

        // Modelview write / push / write / pop returns the saved matrix.
        do_cmd("mv_write_a", 1'b0, 1'b1, a,  1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("mv_push",    1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_cmd("mv_write_b", 1'b0, 1'b1, b,  1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("mv_pop",     1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mv_pop_is_a", {matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3}, a);
        peek_at("proj_untouched", 1'b1);

        // Projection overflow at DEPTH+1 pushes.
        for (int i = 0; i < DEPTH + 1; i++) do_cmd($sformatf("pj_push%0d", i), 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pj_depth_full", 512'(depth_proj), 512'(4'd8));
        check("pj_ovf_set",    512'(overflow),   512'(1'b1));
        do_cmd("pj_err_clr", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Underflow from an empty modelview stack; set beats clear.
        apply_reset("reset2");
        do_cmd("mv_pop_empty",  1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_cmd("mv_pop_and_clr", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("unf_set_wins", 512'(underflow), 512'(1'b1));
        do_cmd("mv_clr", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Write outranks push and pop in the same cycle.
        do_cmd("mv_prio", 1'b0, 1'b1, c, 1'b0, 1'b1, 1'b1, 1'b0);
        check("prio_top_c", {matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3}, c);
        do_cmd("mv_ident_over_push", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Projection write D, push, identity, mode toggle, pop back to D.
        apply_reset("reset3");
        do_cmd("mv_write_c", 1'b0, 1'b1, c,  1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("pj_write_d", 1'b1, 1'b1, d,  1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("pj_push",    1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_cmd("pj_ident",   1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        peek_at("toggle_mv", 1'b0);
        check("toggle_mv_is_c", {matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3}, c);
        peek_at("toggle_pj", 1'b1);
        do_cmd("pj_pop_d",   1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pj_pop_is_d", {matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3}, d);

        // Random command mix against the model.
        for (int n = 0; n < 80; n++) begin
            for (int k = 0; k < 16; k++) rnd[32*k +: 32] = $urandom;
            do_cmd($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) < 2), rnd, ($urandom_range(0, 9) < 1),
                   ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                   ($urandom_range(0, 9) < 1));
        end

        // Reset asserted mid-cycle with a push pending: state clears at once, the push is lost.
        do_cmd("pre_rst_write", 1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        matrix_mode_in = 1'b0;
        push = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_exp("async_rst");
        compare_one();
        @(negedge clk);
        push  = 1'b0;
        rst_n = 1'b1;
        #1;
        push_exp("post_rst");
        compare_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
